// File: rtl/cbus_arbiter.sv
// cbus_arbiter: merges the instruction-side and data-side CBus masters onto a
// single CBus port towards the CBus-to-AXI converter. One transaction is
// granted at a time. The granted master sees the converter's response live,
// and the other master sees an all-zero response. Ties are resolved
// round-robin (FAIR=1) or always in favour of the data side (FAIR=0).

typedef struct packed {
  logic        valid;
  logic        is_write;
  logic [2:0]  size;
  logic [31:0] addr;
  logic [3:0]  strobe;
  logic [31:0] data;
  logic [3:0]  len;
} cbus_req_t;

typedef struct packed {
  logic        ready;
  logic        last;
  logic [31:0] data;
} cbus_resp_t;

module cbus_arbiter #(
  parameter bit FAIR = 1'b1
) (
  input  logic       clk,
  input  logic       resetn,
  input  cbus_req_t  ireq,
  output cbus_resp_t iresp,
  input  cbus_req_t  dreq,
  output cbus_resp_t dresp,
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_e state_q, state_d;
  logic   grant_q, grant_d;
  logic   last_grant_q, last_grant_d;

  // Arbitration decision made in IDLE for the requests currently presented.
  logic   both_valid;
  logic   any_valid;
  logic   pick;

  assign both_valid = ireq.valid & dreq.valid;
  assign any_valid  = ireq.valid | dreq.valid;

  // Tie-break: round-robin flips away from the last winner, otherwise data wins.
  always_comb begin
    pick = GRANT_I;
    if (both_valid) begin
      pick = FAIR ? ~last_grant_q : GRANT_D;
    end else if (dreq.valid) begin
      pick = GRANT_D;
    end
  end

  // State, grant and round-robin history; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      grant_q      <= GRANT_I;
      last_grant_q <= GRANT_I;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next-state: grant a new owner from IDLE, release it on the final beat.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d      = BUSY;
          grant_d      = pick;
          last_grant_d = pick;
        end
      end
      BUSY: begin
        // A dropped valid from the owner does not release the bus; only the
        // converter's final beat ends the transaction.
        if (oresp.ready && oresp.last) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output steering: live pass-through for the owner, zeros everywhere else.
  always_comb begin
    oreq  = '0;
    iresp = '0;
    dresp = '0;
    if (state_q == BUSY) begin
      if (grant_q == GRANT_D) begin
        oreq  = dreq;
        dresp = oresp;
      end else begin
        oreq  = ireq;
        iresp = oresp;
      end
    end
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Bench for cbus_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level ownership model, for both FAIR settings.

module tb_cbus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  cbus_req_t  ireq, dreq, oreq1, oreq0;
  cbus_resp_t oresp, iresp1, dresp1, iresp0, dresp0;

  int errors = 0;
  int checks = 0;

  cbus_arbiter #(.FAIR(1'b1)) dut1 (
    .clk(clk), .resetn(resetn),
    .ireq(ireq), .iresp(iresp1),
    .dreq(dreq), .dresp(dresp1),
    .oreq(oreq1), .oresp(oresp)
  );

  cbus_arbiter #(.FAIR(1'b0)) dut0 (
    .clk(clk), .resetn(resetn),
    .ireq(ireq), .iresp(iresp0),
    .dreq(dreq), .dresp(dresp0),
    .oreq(oreq0), .oresp(oresp)
  );

  // Reference model: who owns the bus (-1 nobody, 0 instruction, 1 data)
  // and who won most recently (starts as instruction, so data wins the first tie).
  int own1 = -1, last1 = 0;
  int own0 = -1, last0 = 0;

  function automatic int choose(input bit fair, input int last_owner,
                                input logic iv, input logic dv);
    if (iv && dv) return fair ? (1 - last_owner) : 1;
    return dv ? 1 : 0;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      own1  <= -1; last1 <= 0;
      own0  <= -1; last0 <= 0;
    end else begin
      if (own1 < 0) begin
        if (ireq.valid || dreq.valid) begin
          own1  <= choose(1'b1, last1, ireq.valid, dreq.valid);
          last1 <= choose(1'b1, last1, ireq.valid, dreq.valid);
        end
      end else if (oresp.ready && oresp.last) begin
        own1 <= -1;
      end
      if (own0 < 0) begin
        if (ireq.valid || dreq.valid) begin
          own0  <= choose(1'b0, last0, ireq.valid, dreq.valid);
          last0 <= choose(1'b0, last0, ireq.valid, dreq.valid);
        end
      end else if (oresp.ready && oresp.last) begin
        own0 <= -1;
      end
    end
  end

  task automatic idle_inputs();
    ireq  = '0;
    dreq  = '0;
    oresp = '0;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    idle_inputs();
    resetn = 1'b0;
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    resetn = 1'b0;
    ireq.valid = 1'b1; dreq.valid = 1'b1;
    oresp.ready = 1'b1; oresp.last = 1'b1; oresp.data = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++;
      if (oreq1 !== '0 || iresp1 !== '0 || dresp1 !== '0) begin
        errors++;
        $display("FAIL reset_outputs_f1 k=%0d oreq=%h iresp=%h dresp=%h required all zero", k, oreq1, iresp1, dresp1);
      end
      checks++;
      if (oreq0 !== '0 || iresp0 !== '0 || dresp0 !== '0) begin
        errors++;
        $display("FAIL reset_outputs_f0 k=%0d oreq=%h iresp=%h dresp=%h required all zero", k, oreq0, iresp0, dresp0);
      end
    end
    @(negedge clk);
    idle_inputs();
    resetn = 1'b1;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    idle_inputs();
    ireq.valid = 1'b1; ireq.addr = 32'hBFC0_0000; ireq.len = 4'd0; ireq.size = 3'd2;
    #1;
    checks++;
    if (oreq1.valid !== 1'b0) begin
      errors++;
      $display("FAIL read_idle_t oreq.valid=%b required 0", oreq1.valid);
    end
    @(negedge clk); #1;
    checks++;
    if (oreq1.valid !== 1'b1 || oreq1.addr !== 32'hBFC0_0000) begin
      errors++;
      $display("FAIL read_oreq_t1 valid=%b addr=%h required 1/bfc00000", oreq1.valid, oreq1.addr);
    end
    @(negedge clk);
    oresp.ready = 1'b1; oresp.last = 1'b1; oresp.data = 32'h3C08_0001;
    #1;
    checks++;
    if (iresp1 !== {1'b1, 1'b1, 32'h3C08_0001} || dresp1 !== '0) begin
      errors++;
      $display("FAIL read_iresp iresp=%h dresp=%h required 3_3c080001/0", iresp1, dresp1);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (oreq1 !== '0 || iresp1 !== '0) begin
      errors++;
      $display("FAIL read_back_idle oreq=%h iresp=%h required zero", oreq1, iresp1);
    end
  endtask

  task automatic test_fair_tie();
    reset_pulse();
    ireq.valid = 1'b1; ireq.addr = 32'h1;
    dreq.valid = 1'b1; dreq.addr = 32'h2;
    oresp.ready = 1'b1; oresp.last = 1'b1; oresp.data = 32'h55;
    for (int k = 0; k < 8; k++) begin
      logic [31:0] exp_addr;
      if (k > 0) @(negedge clk);
      #1;
      checks++;
      if (k % 2 == 0) begin
        if (oreq1.valid !== 1'b0) begin
          errors++;
          $display("FAIL fair_gap k=%0d oreq.valid=%b required 0", k, oreq1.valid);
        end
      end else begin
        exp_addr = ((k / 2) % 2 == 0) ? 32'h2 : 32'h1;
        if (oreq1.addr !== exp_addr || dresp1.ready !== (exp_addr == 32'h2) ||
            iresp1.ready !== (exp_addr == 32'h1)) begin
          errors++;
          $display("FAIL fair_order k=%0d addr=%h dready=%b iready=%b required addr %h", k, oreq1.addr, dresp1.ready, iresp1.ready, exp_addr);
        end
      end
    end
  endtask

  task automatic test_fixed_tie();
    reset_pulse();
    ireq.valid = 1'b1; ireq.addr = 32'h1;
    dreq.valid = 1'b1; dreq.addr = 32'h2;
    oresp.ready = 1'b1; oresp.last = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++;
      if (iresp0.ready !== 1'b0) begin
        errors++;
        $display("FAIL fixed_iready k=%0d got %b required 0", k, iresp0.ready);
      end
      if (k % 2 == 1) begin
        checks++;
        if (oreq0.valid !== 1'b1 || oreq0.addr !== 32'h2) begin
          errors++;
          $display("FAIL fixed_grant k=%0d valid=%b addr=%h required 1/2", k, oreq0.valid, oreq0.addr);
        end
      end
    end
  endtask

  task automatic test_write_burst();
    logic [31:0] dat [5] = '{32'h11, 32'h22, 32'h33, 32'h33, 32'h44};
    logic        rdy [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic        lst [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int pulses = 0;
    reset_pulse();
    dreq.valid = 1'b1; dreq.is_write = 1'b1; dreq.len = 4'd3;
    dreq.addr = 32'h1000; dreq.strobe = 4'hF; dreq.data = 32'h11;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      dreq.data   = dat[s];
      dreq.strobe = 4'hF ^ s[3:0];
      oresp.ready = rdy[s];
      oresp.last  = lst[s];
      #1;
      if (dresp1.ready === 1'b1) pulses++;
      checks++;
      if (oreq1.data !== dat[s] || oreq1.strobe !== (4'hF ^ s[3:0]) || oreq1.valid !== 1'b1 ||
          dresp1.ready !== rdy[s] || dresp1.last !== lst[s] || iresp1 !== '0) begin
        errors++;
        $display("FAIL burst_beat s=%0d data=%h strb=%h dready=%b dlast=%b iresp=%h required %h/%h/%b/%b/0",
                 s, oreq1.data, oreq1.strobe, dresp1.ready, dresp1.last, iresp1, dat[s], 4'hF ^ s[3:0], rdy[s], lst[s]);
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (pulses != 4 || oreq1 !== '0) begin
      errors++;
      $display("FAIL burst_end pulses=%0d oreq=%h required 4/zero", pulses, oreq1);
    end
  endtask

  task automatic test_reset_mid_burst();
    reset_pulse();
    dreq.valid = 1'b1; dreq.addr = 32'h2000; dreq.len = 4'd3;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      oresp.ready = 1'b1; oresp.last = 1'b0; oresp.data = 32'hA0 + b;
      #1;
      checks++;
      if (dresp1.ready !== 1'b1 || dresp1.data !== 32'hA0 + b) begin
        errors++;
        $display("FAIL midrst_beat b=%0d dresp=%h required ready with %h", b, dresp1, 32'hA0 + b);
      end
    end
    @(negedge clk);
    resetn = 1'b0;
    oresp.data = 32'hA2;
    #1;
    checks++;
    if (oreq1.valid !== 1'b0 || dresp1 !== '0) begin
      errors++;
      $display("FAIL midrst_abort oreq.valid=%b dresp=%h required 0/zero", oreq1.valid, dresp1);
    end
    @(negedge clk);
    idle_inputs();
    resetn = 1'b1;
    ireq.valid = 1'b1; ireq.addr = 32'h3000;
    #1;
    checks++;
    if (oreq1.valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_idle oreq.valid=%b required 0", oreq1.valid);
    end
    @(negedge clk); #1;
    checks++;
    if (oreq1.valid !== 1'b1 || oreq1.addr !== 32'h3000 || dresp1 !== '0) begin
      errors++;
      $display("FAIL midrst_regrant valid=%b addr=%h dresp=%h required 1/3000/0", oreq1.valid, oreq1.addr, dresp1);
    end
    @(negedge clk);
    oresp.ready = 1'b1; oresp.last = 1'b1;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_drop_valid();
    reset_pulse();
    ireq.valid = 1'b1; ireq.addr = 32'h40;
    @(negedge clk); #1;
    checks++;
    if (oreq1.valid !== 1'b1) begin
      errors++;
      $display("FAIL drop_granted oreq.valid=%b required 1", oreq1.valid);
    end
    @(negedge clk);
    ireq.valid = 1'b0;
    #1;
    checks++;
    if (oreq1.valid !== 1'b0 || oreq1.addr !== 32'h40) begin
      errors++;
      $display("FAIL drop_live valid=%b addr=%h required 0/40", oreq1.valid, oreq1.addr);
    end
    @(negedge clk);
    ireq.valid = 1'b1;
    oresp.ready = 1'b1; oresp.last = 1'b1;
    #1;
    checks++;
    if (oreq1.valid !== 1'b1 || iresp1.ready !== 1'b1) begin
      errors++;
      $display("FAIL drop_still_busy valid=%b iready=%b required 1/1", oreq1.valid, iresp1.ready);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (oreq1 !== '0) begin
      errors++;
      $display("FAIL drop_release oreq=%h required zero", oreq1);
    end
  endtask

  task automatic test_random();
    cbus_req_t  eq1, eq0;
    cbus_resp_t ei1, ed1, ei0, ed0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      resetn = ($urandom_range(0, 59) != 0);
      ireq.valid    = ($urandom_range(0, 2) != 0);
      ireq.is_write = $urandom_range(0, 1);
      ireq.size     = 3'($urandom_range(0, 7));
      ireq.addr     = $urandom;
      ireq.strobe   = 4'($urandom_range(0, 15));
      ireq.data     = $urandom;
      ireq.len      = 4'($urandom_range(0, 15));
      dreq.valid    = ($urandom_range(0, 2) != 0);
      dreq.is_write = $urandom_range(0, 1);
      dreq.size     = 3'($urandom_range(0, 7));
      dreq.addr     = $urandom;
      dreq.strobe   = 4'($urandom_range(0, 15));
      dreq.data     = $urandom;
      dreq.len      = 4'($urandom_range(0, 15));
      oresp.ready   = $urandom_range(0, 1);
      oresp.last    = ($urandom_range(0, 2) == 0);
      oresp.data    = $urandom;
      #1;
      eq1 = (own1 < 0) ? cbus_req_t'('0) : ((own1 == 1) ? dreq : ireq);
      ei1 = (own1 == 0) ? oresp : cbus_resp_t'('0);
      ed1 = (own1 == 1) ? oresp : cbus_resp_t'('0);
      eq0 = (own0 < 0) ? cbus_req_t'('0) : ((own0 == 1) ? dreq : ireq);
      ei0 = (own0 == 0) ? oresp : cbus_resp_t'('0);
      ed0 = (own0 == 1) ? oresp : cbus_resp_t'('0);
      checks++;
      if (oreq1 !== eq1 || iresp1 !== ei1 || dresp1 !== ed1) begin
        errors++;
        $display("FAIL rand_f1 c=%0d oreq=%h iresp=%h dresp=%h required %h %h %h", c, oreq1, iresp1, dresp1, eq1, ei1, ed1);
      end
      checks++;
      if (oreq0 !== eq0 || iresp0 !== ei0 || dresp0 !== ed0) begin
        errors++;
        $display("FAIL rand_f0 c=%0d oreq=%h iresp=%h dresp=%h required %h %h %h", c, oreq0, iresp0, dresp0, eq0, ei0, ed0);
      end
    end
    @(negedge clk);
    idle_inputs();
    resetn = 1'b1;
  endtask

  initial begin
    idle_inputs();
    resetn = 1'b1;
    #2;
    resetn = 1'b0;
    test_reset();
    test_single_read();
    test_fair_tie();
    test_fixed_tie();
    test_write_burst();
    test_reset_mid_burst();
    test_drop_valid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
